// File: rtl/vga_frame_writer.sv
// vga_frame_writer: unpacks 32-bit pixel words into framed RGB444 pixel writes; define VGA_FRAME_WRITER_GRAY_EN for 4x8-bit grayscale input words
module vga_frame_writer #(
  parameter int H_PIX = 512,
  parameter int V_PIX = 256,
  localparam int NPIX = H_PIX * V_PIX,
  localparam int CNT_W = $clog2(NPIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             pix_we,
  output logic [11:0]      pix_wdata,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_cnt
);
`ifdef VGA_FRAME_WRITER_GRAY_EN
  localparam int PPW = 4;
`else
  localparam int PPW = 2;
`endif
  localparam int SLOT_W = $clog2(PPW);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state_q;
  logic [31:0] hold_q, word_d;
  logic hold_vld_q, vld_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic last_slot, last_pix, accept;
  // hold_vld_q/slot_q describe the pixel currently on pix_wdata, so a new word
  // can be taken while the last slot of the previous one is being written
  function automatic logic [11:0] unpack(input logic [31:0] w, input logic [SLOT_W-1:0] s);
`ifdef VGA_FRAME_WRITER_GRAY_EN
    return {w[{s, 3'b111} -: 4], w[{s, 3'b111} -: 4], w[{s, 3'b111} -: 4]};
`else
    return w[{s, 4'b0000} +: 12];
`endif
  endfunction
  assign last_slot = slot_q == SLOT_W'(PPW - 1);
  assign last_pix  = pix_we && pix_cnt == CNT_W'(NPIX - 1);
  assign in_ready  = state_q == RUN && (!hold_vld_q || last_slot) && !last_pix;
  assign accept    = in_valid && in_ready;
  // next holding-register contents: a fresh word starts at slot 0, otherwise advance one slot
  always_comb begin
    word_d = accept ? in_data : hold_q;
    slot_d = accept ? '0 : slot_q + SLOT_W'(1);
    vld_d  = accept || (hold_vld_q && !last_slot);
  end
  // frame FSM with registered strobes, pixel output and saturating pixel count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      slot_q      <= '0;
      pix_we      <= 1'b0;
      pix_wdata   <= '0;
      pix_cnt     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= ARM;
          frame_start <= 1'b1;
          pix_cnt     <= '0;
        end
        ARM: state_q <= RUN;
        RUN: if (start) begin
          state_q     <= ARM;
          frame_start <= 1'b1;
          pix_cnt     <= '0;
          hold_vld_q  <= 1'b0;
          pix_we      <= 1'b0;
        end else begin
          hold_q     <= word_d;
          slot_q     <= slot_d;
          hold_vld_q <= vld_d;
          pix_we     <= vld_d;
          if (vld_d) pix_wdata <= unpack(word_d, slot_d);
          if (last_pix) begin
            state_q    <= DONE;
            frame_done <= 1'b1;
          end else if (pix_we) pix_cnt <= pix_cnt + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_frame_writer.sv
// tb_vga_frame_writer: randomized bench for vga_frame_writer against a pixel-stream reference model
module tb_vga_frame_writer;
  localparam int H = 16, V = 8, NPIX = H * V, CW = $clog2(NPIX);
`ifdef VGA_FRAME_WRITER_GRAY_EN
  localparam int PPW = 4;
  localparam logic [31:0] W0 = 32'hF0A5_3C00;
`else
  localparam int PPW = 2;
  localparam logic [31:0] W0 = 32'h0ABC_0123;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, pix_we, frame_start, frame_done;
  logic [11:0] pix_wdata;
  logic [CW-1:0] pix_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  vga_frame_writer #(.H_PIX(H), .V_PIX(V)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pix_we(pix_we), .pix_wdata(pix_wdata),
    .frame_start(frame_start), .frame_done(frame_done), .pix_cnt(pix_cnt)
  );
  typedef struct { int due; logic [11:0] pix; } ev_t;
  ev_t q[$];
  int t = 0, cnt = 0;
  bit armed = 0, running = 0, closing = 0;
  logic [11:0] last_pix = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, t);
    end
  endtask
  function automatic logic [11:0] model_pix(input logic [31:0] w, input int k);
`ifdef VGA_FRAME_WRITER_GRAY_EN
    int g;
    g = int'((w >> (8 * k)) & 32'hFF);
    return 12'((g / 16) * 273);
`else
    return 12'((w >> (16 * k)) & 32'hFFF);
`endif
  endfunction
  // one clock: compare at negedge against the model, then advance the model
  task automatic cycle();
    bit we_e, rdy_e, n_armed, n_closing;
    @(negedge clk);
    we_e  = q.size() > 0 && q[0].due == t;
    rdy_e = running && (q.size() == 0 || (q.size() == 1 && we_e)) && !(we_e && cnt == NPIX - 1);
    chk("pix_we", 32'(pix_we), 32'(we_e));
    chk("pix_wdata", 32'(pix_wdata), 32'(we_e ? q[0].pix : last_pix));
    chk("pix_cnt", 32'(pix_cnt), cnt);
    chk("frame_start", 32'(frame_start), 32'(armed));
    chk("frame_done", 32'(frame_done), 32'(closing));
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    if (we_e) begin
      last_pix = q[0].pix;
      void'(q.pop_front());
    end
    n_armed = 0;
    n_closing = 0;
    if (start && !armed && !closing) begin
      q.delete();
      running = 0;
      cnt = 0;
      n_armed = 1;
    end else if (armed) running = 1;
    else if (running) begin
      if (we_e && cnt == NPIX - 1) begin
        running = 0;
        n_closing = 1;
      end else if (we_e) cnt++;
      if (in_valid && rdy_e)
        for (int k = 0; k < PPW; k++) q.push_back('{t + 1 + k, model_pix(in_data, k)});
    end
    armed = n_armed;
    closing = n_closing;
    @(posedge clk);
    #1;
    t++;
  endtask
  // mode 0: in_valid held high, 1: toggling, 2: random; stops at frame end or stop_cnt pixels
  task automatic run(input int mode, input int stop_cnt, input int limit);
    int n;
    n = 0;
    while (!closing && !(running && cnt >= stop_cnt) && n < limit) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'(t % 2) : 1'($urandom_range(0, 99) < 60);
      in_data = (running && cnt == 0 && q.size() == 0) ? W0 : $urandom();
      cycle();
      n++;
    end
    in_valid = 1'b0;
  endtask
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_pix_we", 32'(pix_we), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_pix_cnt", 32'(pix_cnt), 0);
    chk("rst_pix_wdata", 32'(pix_wdata), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    q.delete();
    running = 0;
    armed = 0;
    closing = 0;
    cnt = 0;
    last_pix = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t++;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix_we", 32'(pix_we), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_pix_cnt", 32'(pix_cnt), 0);
    chk("reset_frame_start", 32'(frame_start), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    chk("reset_pix_wdata", 32'(pix_wdata), 0);
    rst = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    in_valid = 1'b1;
    in_data = W0;
    cycle();
    start = 1'b0;
    run(0, NPIX + 1, 4 * NPIX);
    chk("frame1_end", 32'(closing), 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    chk("frame1_final_cnt", 32'(pix_cnt), NPIX - 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(1, 40, 4 * NPIX);
    chk("abort_point", 32'(cnt >= 40), 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(2, NPIX + 1, 8 * NPIX);
    chk("frame2_end", 32'(closing), 1);
    repeat (3) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(2, 60, 8 * NPIX);
    async_reset();
    repeat (5) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(2, NPIX + 1, 8 * NPIX);
    chk("frame3_end", 32'(closing), 1);
    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
